dma_desc_sequencer: RTL and testbench

- Descriptor queue and launcher that sits directly upstream of the simple single-word-per-beat DMA engine and drives its start/src_addr/dst_addr/len inputs.
- Software or a control block pushes transfer descriptors into a small FIFO. The sequencer launches them one at a time, holds the DMA operands stable for the whole transfer, detects completion, and counts completions.
- Raises a sticky interrupt on each completion.

---
 rtl/dma_pkg.sv | 20 ++
 rtl/dma_desc_sequencer_if.sv | 41 ++++
 rtl/dma_desc_fifo.sv | 53 +++++
 rtl/dma_desc_sequencer.sv | 84 ++++++++
 tb/tb_dma_desc_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared types for the DMA descriptor sequencer: FSM encoding, descriptor payload, default widths.
package dma_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        SETTLE    = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] src;
        logic [DEF_ADDR_W-1:0] dst;
        logic [DEF_LEN_W-1:0]  len;
    } desc_t;

endpackage

// File: rtl/dma_desc_sequencer_if.sv
// Descriptor push port, DMA launch port and status signals of the sequencer.
interface dma_desc_sequencer_if
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              enable;
    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W-1:0] desc_src;
    logic [ADDR_W-1:0] desc_dst;
    logic [LEN_W-1:0]  desc_len;
    logic              dma_start;
    logic [ADDR_W-1:0] dma_src_addr;
    logic [ADDR_W-1:0] dma_dst_addr;
    logic [LEN_W-1:0]  dma_len;
    logic              dma_done;
    logic              busy;
    logic              irq;
    logic              irq_clear;
    logic [CNT_W-1:0]  completed_count;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output enable, desc_valid, desc_src, desc_dst, desc_len, dma_done, irq_clear,
        input  desc_ready, dma_start, dma_src_addr, dma_dst_addr, dma_len,
        input  busy, irq, completed_count, fifo_level
    );

    modport slave (
        input  enable, desc_valid, desc_src, desc_dst, desc_len, dma_done, irq_clear,
        output desc_ready, dma_start, dma_src_addr, dma_dst_addr, dma_len,
        output busy, irq, completed_count, fifo_level
    );

endinterface

// File: rtl/dma_desc_fifo.sv
// Synchronous circular FIFO of descriptors; no bypass, so a push is poppable the following cycle.
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  desc_t                    din,
    input  logic                     pop,
    output desc_t                    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    desc_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally; level is kept separately to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dma_desc_sequencer.sv
// Queues DMA descriptors and launches them one at a time, holding operands until done.
module dma_desc_sequencer
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dma_desc_sequencer_if.slave  bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    state_t           state;
    desc_t            head;
    desc_t            push_desc;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             done_hit;
    logic [LVL_W-1:0] level;

    assign push_desc = '{src: DEF_ADDR_W'(bus.desc_src),
                         dst: DEF_ADDR_W'(bus.desc_dst),
                         len: DEF_LEN_W'(bus.desc_len)};
    assign push      = bus.desc_valid && !full;
    assign pop       = (state == IDLE) && bus.enable && !empty;
    assign done_hit  = (state == WAIT_DONE) && bus.dma_done;

    dma_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_desc),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign bus.desc_ready = !full;
    assign bus.fifo_level = level;
    assign bus.dma_start  = (state == LAUNCH);
    assign bus.busy       = (state != IDLE);

    // done is ignored in LAUNCH/SETTLE because the DMA still shows the previous transfer's done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            bus.dma_src_addr    <= '0;
            bus.dma_dst_addr    <= '0;
            bus.dma_len         <= '0;
            bus.completed_count <= '0;
            bus.irq             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.dma_src_addr <= ADDR_W'(head.src);
                        bus.dma_dst_addr <= ADDR_W'(head.dst);
                        bus.dma_len      <= LEN_W'(head.len);
                        state            <= LAUNCH;
                    end
                end
                LAUNCH:    state <= SETTLE;
                SETTLE:    state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (bus.dma_done) begin
                        bus.completed_count <= bus.completed_count + CNT_W'(1);
                        state               <= IDLE;
                    end
                end
            endcase

            if (done_hit)           bus.irq <= 1'b1;
            else if (bus.irq_clear) bus.irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_desc_sequencer.sv
// Directed bench for dma_desc_sequencer with a behavioural DMA that holds done until the next start.
module tb_dma_desc_sequencer;
    import dma_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        desc_t d;
        logic  exp_ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_desc_sequencer_if #(.ADDR_W(DEF_ADDR_W), .LEN_W(DEF_LEN_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

    dma_desc_sequencer #(.DEPTH(DEPTH), .ADDR_W(DEF_ADDR_W), .LEN_W(DEF_LEN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int viol   = 0;

    // DMA model: clears done on the start edge, raises it len+1 edges later, then holds it.
    logic                 man_mode = 1'b0;
    logic                 man_done = 1'b0;
    logic                 auto_done;
    logic                 dma_run;
    logic [DEF_LEN_W-1:0] dma_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_done <= 1'b0;
            dma_run   <= 1'b0;
            dma_cnt   <= '0;
        end else if (bus.dma_start) begin
            auto_done <= 1'b0;
            dma_run   <= 1'b1;
            dma_cnt   <= bus.dma_len;
        end else if (dma_run) begin
            if (dma_cnt == '0) begin
                auto_done <= 1'b1;
                dma_run   <= 1'b0;
            end else begin
                dma_cnt <= dma_cnt - 1'b1;
            end
        end
    end

    assign bus.dma_done = man_mode ? man_done : auto_done;

    always @(posedge clk) cyc <= cyc + 1;

    desc_t log_q[$];
    int    start_cyc[$];
    desc_t cur;

    // Launch log plus operand-hold monitor for every busy cycle.
    always @(negedge clk) begin
        if (bus.dma_start) begin
            log_q.push_back('{src: bus.dma_src_addr, dst: bus.dma_dst_addr, len: bus.dma_len});
            start_cyc.push_back(cyc);
        end
        if (bus.busy && log_q.size() > 0) begin
            cur = '{src: bus.dma_src_addr, dst: bus.dma_dst_addr, len: bus.dma_len};
            if (cur != log_q[log_q.size()-1]) viol++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input desc_t d);
        bus.desc_valid = 1'b1;
        bus.desc_src   = d.src;
        bus.desc_dst   = d.dst;
        bus.desc_len   = d.len;
        tick();
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!bus.dma_start && n < 60) begin
            tick();
            n++;
        end
        chk(name, 128'(bus.dma_start), 128'(1));
    endtask

    task automatic wait_count(input string name, input int target);
        int n = 0;
        while (int'(bus.completed_count) != target && n < 300) begin
            tick();
            n++;
        end
        chk(name, 128'(bus.completed_count), 128'(target));
    endtask

    vec_t  tbl[5];
    desc_t a, b, c, z;
    int    c0;
    int    nlog;

    initial begin
        tbl[0] = '{d: '{src: 32'h0000_1100, dst: 32'h0000_2100, len: 8'd2}, exp_ready: 1'b1};
        tbl[1] = '{d: '{src: 32'h0000_1200, dst: 32'h0000_2200, len: 8'd0}, exp_ready: 1'b1};
        tbl[2] = '{d: '{src: 32'h0000_1300, dst: 32'h0000_2300, len: 8'd5}, exp_ready: 1'b1};
        tbl[3] = '{d: '{src: 32'h0000_1400, dst: 32'h0000_2400, len: 8'd1}, exp_ready: 1'b1};
        tbl[4] = '{d: '{src: 32'h0000_1500, dst: 32'h0000_2500, len: 8'd7}, exp_ready: 1'b0};

        bus.enable     = 1'b0;
        bus.desc_valid = 1'b0;
        bus.desc_src   = '0;
        bus.desc_dst   = '0;
        bus.desc_len   = '0;
        bus.irq_clear  = 1'b0;
        man_mode       = 1'b1;
        tick();
        tick();

        chk("reset_ready", 128'(bus.desc_ready), 128'(1));
        chk("reset_start", 128'(bus.dma_start), 128'(0));
        chk("reset_busy",  128'(bus.busy), 128'(0));
        chk("reset_irq",   128'(bus.irq), 128'(0));
        chk("reset_count", 128'(bus.completed_count), 128'(0));
        chk("reset_level", 128'(bus.fifo_level), 128'(0));
        chk("reset_src",   128'(bus.dma_src_addr), 128'(0));
        rst = 1'b0;
        tick();

        // Single descriptor: start two cycles after acceptance, done at cycle 10.
        bus.enable = 1'b1;
        c0 = cyc;
        push_desc('{src: 32'h0000_1000, dst: 32'h0000_2000, len: 8'd3});
        chk("single_level", 128'(bus.fifo_level), 128'(1));
        chk("single_early", 128'(bus.dma_start), 128'(0));
        tick();
        chk("single_start", 128'(bus.dma_start), 128'(1));
        chk("single_src",   128'(bus.dma_src_addr), 128'h1000);
        chk("single_dst",   128'(bus.dma_dst_addr), 128'h2000);
        chk("single_len",   128'(bus.dma_len), 128'(3));
        tick();
        chk("single_pulse", 128'(bus.dma_start), 128'(0));
        while (cyc < c0 + 10) tick();
        man_done = 1'b1;
        chk("single_nodone", 128'(bus.completed_count), 128'(0));
        tick();
        man_done = 1'b0;
        chk("single_count", 128'(bus.completed_count), 128'(1));
        chk("single_irq",   128'(bus.irq), 128'(1));
        chk("single_idle",  128'(bus.busy), 128'(0));
        chk("single_nstart", 128'(log_q.size()), 128'(1));
        bus.irq_clear = 1'b1;
        tick();
        bus.irq_clear = 1'b0;
        chk("single_irqclr", 128'(bus.irq), 128'(0));

        // Fill to full with enable low, then drain in order with a stale-done DMA.
        man_mode   = 1'b0;
        bus.enable = 1'b0;
        log_q.delete();
        start_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_ready%0d", i), 128'(bus.desc_ready), 128'(tbl[i].exp_ready));
            push_desc(tbl[i].d);
        end
        chk("fill_level", 128'(bus.fifo_level), 128'(4));
        chk("fill_ready_full", 128'(bus.desc_ready), 128'(0));
        chk("fill_hold", 128'(log_q.size()), 128'(0));
        bus.enable = 1'b1;
        wait_count("fill_count", 5);
        chk("fill_nstart", 128'(log_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk($sformatf("fill_order%0d", i), 128'(log_q[i]), 128'(tbl[i].d));
            if (i > 0)
                chk($sformatf("fill_gap%0d", i), 128'(start_cyc[i] - start_cyc[i-1]),
                    128'(int'(tbl[i-1].d.len) + 4));
        end
        chk("fill_empty", 128'(bus.fifo_level), 128'(0));

        // Operand stability while new descriptors arrive mid-transfer.
        log_q.delete();
        start_cyc.delete();
        a = '{src: 32'h0000_A000, dst: 32'h0000_B000, len: 8'd6};
        b = '{src: 32'h0000_A100, dst: 32'h0000_B100, len: 8'd3};
        c = '{src: 32'h0000_A200, dst: 32'h0000_B200, len: 8'd1};
        push_desc(a);
        wait_start("stab_startA");
        tick();
        push_desc(b);
        push_desc(c);
        wait_count("stab_count", 8);
        nlog = log_q.size();
        chk("stab_nstart", 128'(nlog), 128'(3));
        if (nlog == 3) begin
            chk("stab_A",   128'(log_q[0]), 128'(a));
            chk("stab_B",   128'(log_q[1]), 128'(b));
            chk("stab_C",   128'(log_q[2]), 128'(c));
            chk("stab_gapB", 128'(start_cyc[1] - start_cyc[0]), 128'(10));
            chk("stab_gapC", 128'(start_cyc[2] - start_cyc[1]), 128'(7));
        end
        chk("stab_hold", 128'(viol), 128'(0));

        // Zero length plus irq set/clear race.
        bus.irq_clear = 1'b1;
        tick();
        bus.irq_clear = 1'b0;
        chk("race_pre_irq", 128'(bus.irq), 128'(0));
        man_mode = 1'b1;
        man_done = 1'b0;
        z = '{src: 32'h0000_C000, dst: 32'h0000_D000, len: 8'd0};
        push_desc(z);
        wait_start("race_start");
        chk("race_len0", 128'(bus.dma_len), 128'(0));
        tick();
        tick();
        man_done      = 1'b1;
        bus.irq_clear = 1'b1;
        tick();
        man_done = 1'b0;
        chk("race_irq_set", 128'(bus.irq), 128'(1));
        chk("race_count",   128'(bus.completed_count), 128'(9));
        chk("race_idle",    128'(bus.busy), 128'(0));
        tick();
        bus.irq_clear = 1'b0;
        chk("race_irq_clr", 128'(bus.irq), 128'(0));

        // Reset mid-transfer with two entries still queued.
        push_desc('{src: 32'h0000_E000, dst: 32'h0000_F000, len: 8'd4});
        push_desc('{src: 32'h0000_E100, dst: 32'h0000_F100, len: 8'd4});
        push_desc('{src: 32'h0000_E200, dst: 32'h0000_F200, len: 8'd4});
        tick();
        chk("rst_pre_busy",  128'(bus.busy), 128'(1));
        chk("rst_pre_level", 128'(bus.fifo_level), 128'(2));
        chk("rst_pre_src",   128'(bus.dma_src_addr), 128'hE000);
        rst = 1'b1;
        #1;
        chk("rst_busy",  128'(bus.busy), 128'(0));
        chk("rst_level", 128'(bus.fifo_level), 128'(0));
        chk("rst_ready", 128'(bus.desc_ready), 128'(1));
        chk("rst_count", 128'(bus.completed_count), 128'(0));
        chk("rst_ops",   128'({bus.dma_src_addr, bus.dma_dst_addr, bus.dma_len}), 128'(0));
        chk("rst_start", 128'(bus.dma_start), 128'(0));
        tick();
        rst  = 1'b0;
        nlog = log_q.size();
        for (int i = 0; i < 10; i++) tick();
        chk("rst_nostart", 128'(log_q.size()), 128'(nlog));
        chk("rst_idle",    128'(bus.busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
